// File: rtl/sweep_ctrl.sv
// Triangular sweep sequencer: walks Count MIN_VAL->MAX_VAL->MIN_VAL for a latched number
// of sweeps, dwelling at each turning point, and drives the Up_M/Dn_M strobes.
module sweep_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 15,
    parameter int unsigned DWELL   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Stop,
    input  logic [7:0]       Cycles,
    output logic [WIDTH-1:0] Count,
    output logic             Up_M,
    output logic             Dn_M,
    output logic             Busy,
    output logic             Done
);

    localparam logic [WIDTH-1:0] MIN_C      = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C      = WIDTH'(MAX_VAL);
    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_HOLD_TOP,
        S_DOWN,
        S_HOLD_BOT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [7:0]       rem_q, rem_d;
    logic [7:0]       dwell_q, dwell_d;
    logic             up_q, dn_q, busy_q, done_q;
    logic             done_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            count_q <= MIN_C;
            rem_q   <= 8'd0;
            dwell_q <= 8'd0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dwell_q <= dwell_d;
            up_q    <= (state_d == S_UP);
            dn_q    <= (state_d == S_DOWN);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
        end
    end

    // Next-state logic; Stop overrides every transition once a run is active.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dwell_d = dwell_q;
        done_d  = 1'b0;

        if (Stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            count_d = MIN_C;
            rem_d   = 8'd0;
            dwell_d = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start && !Stop) begin
                        if (Cycles != 8'd0) begin
                            rem_d   = Cycles;
                            count_d = MIN_C;
                            state_d = S_UP;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_UP: begin
                    if (count_q != MAX_C) begin
                        count_d = count_q + WIDTH'(1);
                    end else if (DWELL == 0) begin
                        state_d = S_DOWN;
                    end else begin
                        dwell_d = 8'd0;
                        state_d = S_HOLD_TOP;
                    end
                end
                S_HOLD_TOP: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = 8'd0;
                        state_d = S_DOWN;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                S_DOWN: begin
                    if (count_q != MIN_C) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        rem_d = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else if (DWELL == 0) begin
                            state_d = S_UP;
                        end else begin
                            dwell_d = 8'd0;
                            state_d = S_HOLD_BOT;
                        end
                    end
                end
                S_HOLD_BOT: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = 8'd0;
                        state_d = S_UP;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign Count = count_q;
    assign Up_M  = up_q;
    assign Dn_M  = dn_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule
